// File: rtl/pooling_output_packer.sv
// Serial-to-parallel packer for pooled results. Words arrive one per cycle
// and are placed MSB-slot first into a PACK_SIZE-word row. A row is closed
// when it fills or when in_last is seen. One closed row can wait in the fill
// register while the output register is still occupied.
module pooling_output_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int PACK_SIZE  = 3,
    parameter int CNT_W      = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_WIDTH-1:0]           in_data,
    input  logic                            in_last,
    input  logic [2:0]                      block_idx_in,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [PACK_SIZE*DATA_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]                out_count,
    output logic [2:0]                      out_block_idx,
    output logic                            err_block
);

    localparam int ROW_W = PACK_SIZE * DATA_WIDTH;

    // Fill register
    logic [DATA_WIDTH-1:0] fslot_q [PACK_SIZE];
    logic [DATA_WIDTH-1:0] fslot_d [PACK_SIZE];
    logic [CNT_W-1:0]      fcnt_q, fcnt_d;
    logic [2:0]            ftag_q, ftag_d;
    logic                  closed_q, closed_d;

    // Output register
    logic                  ovalid_q, ovalid_d;
    logic [ROW_W-1:0]      odata_q, odata_d;
    logic [CNT_W-1:0]      ocount_q, ocount_d;
    logic [2:0]            otag_q, otag_d;
    logic                  err_q, err_d;

    // Row as it would look with this cycle's accepted word included
    logic [DATA_WIDTH-1:0] slot_new [PACK_SIZE];
    logic [ROW_W-1:0]      row_asm;
    logic [CNT_W-1:0]      cnt_new;
    logic [2:0]            tag_new;
    logic                  accept;
    logic                  close_now;
    logic                  out_free;
    logic                  transfer;

    // Slot k occupies the k-th word counted from the MSB end
    generate
        for (genvar gi = 0; gi < PACK_SIZE; gi++) begin : g_pack
            assign row_asm[(PACK_SIZE-gi)*DATA_WIDTH-1 -: DATA_WIDTH] = slot_new[gi];
        end
    endgenerate

    // Accept/close/transfer decisions and next-state of both registers
    always_comb begin
        accept    = in_valid && !closed_q;
        for (int k = 0; k < PACK_SIZE; k++) begin
            slot_new[k] = (accept && fcnt_q == CNT_W'(k)) ? in_data : fslot_q[k];
        end
        cnt_new   = fcnt_q + CNT_W'(accept);
        tag_new   = (accept && fcnt_q == '0) ? block_idx_in : ftag_q;
        close_now = accept && (cnt_new == CNT_W'(PACK_SIZE) || in_last);
        out_free  = !ovalid_q || out_ready;
        // A held row can only move once the consumer takes the current one
        transfer  = (close_now && out_free) || (closed_q && out_ready);

        fslot_d  = slot_new;
        fcnt_d   = cnt_new;
        ftag_d   = tag_new;
        closed_d = closed_q;
        if (transfer) begin
            for (int k = 0; k < PACK_SIZE; k++) begin
                fslot_d[k] = '0;
            end
            fcnt_d   = '0;
            closed_d = 1'b0;
        end else if (close_now) begin
            closed_d = 1'b1;
        end

        ovalid_d = ovalid_q;
        odata_d  = odata_q;
        ocount_d = ocount_q;
        otag_d   = otag_q;
        if (transfer) begin
            ovalid_d = 1'b1;
            odata_d  = row_asm;
            ocount_d = cnt_new;
            otag_d   = tag_new;
        end else if (out_ready) begin
            ovalid_d = 1'b0;
        end

        // Tag drift inside a row is flagged but the word is still packed
        err_d = err_q | (accept && fcnt_q != '0 && block_idx_in != ftag_q);
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < PACK_SIZE; k++) begin
                fslot_q[k] <= '0;
            end
            fcnt_q   <= '0;
            ftag_q   <= '0;
            closed_q <= 1'b0;
            ovalid_q <= 1'b0;
            odata_q  <= '0;
            ocount_q <= '0;
            otag_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            fslot_q  <= fslot_d;
            fcnt_q   <= fcnt_d;
            ftag_q   <= ftag_d;
            closed_q <= closed_d;
            ovalid_q <= ovalid_d;
            odata_q  <= odata_d;
            ocount_q <= ocount_d;
            otag_q   <= otag_d;
            err_q    <= err_d;
        end
    end

    assign in_ready      = !closed_q;
    assign out_valid     = ovalid_q;
    assign out_data      = odata_q;
    assign out_count     = ocount_q;
    assign out_block_idx = otag_q;
    assign err_block     = err_q;

endmodule

// File: tb/tb_pooling_output_packer.sv
// Directed bench for pooling_output_packer: a vector table for single-row
// behaviour plus hand-written backpressure and asynchronous-reset sequences.
module tb_pooling_output_packer;

    localparam int DW = 32;
    localparam int PS = 3;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW-1:0]   in_data = '0;
    logic            in_last = 1'b0;
    logic [2:0]      block_idx_in = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [PS*DW-1:0] out_data;
    logic [CW-1:0]   out_count;
    logic [2:0]      out_block_idx;
    logic            err_block;

    int checks = 0;
    int errors = 0;

    pooling_output_packer #(.DATA_WIDTH(DW), .PACK_SIZE(PS), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .block_idx_in(block_idx_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_block_idx(out_block_idx),
        .err_block(err_block)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            vld;
        logic [DW-1:0]   din;
        logic            last;
        logic [2:0]      tag;
        logic            ordy;
        logic            e_irdy;
        logic            e_ov;
        logic [PS*DW-1:0] e_data;
        logic [CW-1:0]   e_cnt;
        logic [2:0]      e_tag;
        logic            e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic vld, input logic [DW-1:0] din,
                                input logic last, input logic [2:0] tag,
                                input logic ordy, input logic e_irdy,
                                input logic e_ov, input logic [PS*DW-1:0] e_data,
                                input logic [CW-1:0] e_cnt, input logic [2:0] e_tag,
                                input logic e_err);
        vec_t v;
        v.vld = vld; v.din = din; v.last = last; v.tag = tag; v.ordy = ordy;
        v.e_irdy = e_irdy; v.e_ov = e_ov; v.e_data = e_data; v.e_cnt = e_cnt;
        v.e_tag = e_tag; v.e_err = e_err;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [PS*DW-1:0] act,
                       input logic [PS*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then let them settle
    task automatic drive(input logic vld, input logic [DW-1:0] din,
                         input logic last, input logic [2:0] tag, input logic ordy);
        @(negedge clk);
        in_valid = vld; in_data = din; in_last = last;
        block_idx_in = tag; out_ready = ordy;
        #1;
    endtask

    task automatic chk_row(input string name, input logic [PS*DW-1:0] d,
                           input logic [CW-1:0] c, input logic [2:0] t);
        chk({name, ".valid"}, {95'd0, out_valid}, 96'd1);
        chk({name, ".data"}, out_data, d);
        chk({name, ".count"}, {94'd0, out_count}, {94'd0, c});
        chk({name, ".tag"}, {93'd0, out_block_idx}, {93'd0, t});
    endtask

    logic [DW-1:0] bp [1:9];

    initial begin
        // Full row A,B,C tag 2
        add(1, 32'hA0000001, 0, 3'd2, 1, 1, 0, '0, 0, 0, 0);
        add(1, 32'hB0000002, 0, 3'd2, 1, 1, 0, '0, 0, 0, 0);
        add(1, 32'hC0000003, 0, 3'd2, 1, 1, 0, '0, 0, 0, 0);
        add(0, 32'h0, 0, 3'd0, 1, 1, 1, {32'hA0000001, 32'hB0000002, 32'hC0000003}, 3, 2, 0);
        // Short row X,Y(last); next word lands in slot 0
        add(1, 32'h11111111, 0, 3'd3, 1, 1, 0, '0, 0, 0, 0);
        add(1, 32'h22222222, 1, 3'd3, 1, 1, 0, '0, 0, 0, 0);
        add(1, 32'h33333333, 0, 3'd5, 1, 1, 1, {32'h11111111, 32'h22222222, 32'h0}, 2, 3, 0);
        add(1, 32'h44444444, 0, 3'd5, 1, 1, 0, '0, 0, 0, 0);
        add(1, 32'h55555555, 0, 3'd5, 1, 1, 0, '0, 0, 0, 0);
        add(0, 32'h0, 0, 3'd0, 1, 1, 1, {32'h33333333, 32'h44444444, 32'h55555555}, 3, 5, 0);
        // in_last without in_valid is ignored; in_last on slot 2 is a full row
        add(0, 32'hDEADBEEF, 1, 3'd7, 1, 1, 0, '0, 0, 0, 0);
        add(1, 32'h66666666, 0, 3'd1, 1, 1, 0, '0, 0, 0, 0);
        add(1, 32'h77777777, 0, 3'd1, 1, 1, 0, '0, 0, 0, 0);
        add(1, 32'h88888888, 1, 3'd1, 1, 1, 0, '0, 0, 0, 0);
        add(0, 32'h0, 0, 3'd0, 1, 1, 1, {32'h66666666, 32'h77777777, 32'h88888888}, 3, 1, 0);
        // Streaming: 9 words, rows visible on cycles 4, 7, 10
        add(1, 32'h00000001, 0, 3'd0, 1, 1, 0, '0, 0, 0, 0);
        add(1, 32'h00000002, 0, 3'd0, 1, 1, 0, '0, 0, 0, 0);
        add(1, 32'h00000003, 0, 3'd0, 1, 1, 0, '0, 0, 0, 0);
        add(1, 32'h00000004, 0, 3'd0, 1, 1, 1, {32'h1, 32'h2, 32'h3}, 3, 0, 0);
        add(1, 32'h00000005, 0, 3'd0, 1, 1, 0, '0, 0, 0, 0);
        add(1, 32'h00000006, 0, 3'd0, 1, 1, 0, '0, 0, 0, 0);
        add(1, 32'h00000007, 0, 3'd0, 1, 1, 1, {32'h4, 32'h5, 32'h6}, 3, 0, 0);
        add(1, 32'h00000008, 0, 3'd0, 1, 1, 0, '0, 0, 0, 0);
        add(1, 32'h00000009, 0, 3'd0, 1, 1, 0, '0, 0, 0, 0);
        add(0, 32'h0, 0, 3'd0, 1, 1, 1, {32'h7, 32'h8, 32'h9}, 3, 0, 0);
        // Tag mismatch 1,1,4: row keeps tag 1, error is sticky
        add(1, 32'hE0000001, 0, 3'd1, 1, 1, 0, '0, 0, 0, 0);
        add(1, 32'hE0000002, 0, 3'd1, 1, 1, 0, '0, 0, 0, 0);
        add(1, 32'hE0000003, 0, 3'd4, 1, 1, 0, '0, 0, 0, 0);
        add(0, 32'h0, 0, 3'd0, 1, 1, 1, {32'hE0000001, 32'hE0000002, 32'hE0000003}, 3, 1, 1);
        add(0, 32'h0, 0, 3'd0, 1, 1, 0, '0, 0, 0, 1);

        // Reset state, sampled while reset is asserted
        #12;
        chk("rst.in_ready", {95'd0, in_ready}, 96'd1);
        chk("rst.out_valid", {95'd0, out_valid}, 96'd0);
        chk("rst.out_data", out_data, 96'd0);
        chk("rst.out_count", {94'd0, out_count}, 96'd0);
        chk("rst.out_block_idx", {93'd0, out_block_idx}, 96'd0);
        chk("rst.err_block", {95'd0, err_block}, 96'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].vld, vecs[i].din, vecs[i].last, vecs[i].tag, vecs[i].ordy);
            chk($sformatf("vec%0d.in_ready", i), {95'd0, in_ready}, {95'd0, vecs[i].e_irdy});
            chk($sformatf("vec%0d.out_valid", i), {95'd0, out_valid}, {95'd0, vecs[i].e_ov});
            chk($sformatf("vec%0d.err_block", i), {95'd0, err_block}, {95'd0, vecs[i].e_err});
            if (vecs[i].e_ov)
                chk_row($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_cnt, vecs[i].e_tag);
            $display("vec %0d: vld=%0d din=%08h last=%0d tag=%0d ordy=%0d -> irdy=%0d ov=%0d cnt=%0d otag=%0d err=%0d",
                     i, vecs[i].vld, vecs[i].din, vecs[i].last, vecs[i].tag, vecs[i].ordy,
                     in_ready, out_valid, out_count, out_block_idx, err_block);
        end

        // Backpressure: out_ready low, stream 7 words
        for (int k = 1; k <= 9; k++) bp[k] = 32'hB9000000 + k;
        for (int k = 1; k <= 7; k++) begin
            drive(1, bp[k], 0, 3'd2, 0);
            chk($sformatf("bp.w%0d.in_ready", k), {95'd0, in_ready}, {95'd0, (k <= 6)});
            if (k >= 4)
                chk_row($sformatf("bp.w%0d.row1", k), {bp[1], bp[2], bp[3]}, 3, 2);
            else
                chk($sformatf("bp.w%0d.out_valid", k), {95'd0, out_valid}, 96'd0);
            $display("bp word %0d: irdy=%0d ov=%0d", k, in_ready, out_valid);
        end
        drive(1, bp[7], 0, 3'd2, 0);
        chk("bp.hold.in_ready", {95'd0, in_ready}, 96'd0);
        chk_row("bp.hold", {bp[1], bp[2], bp[3]}, 3, 2);
        $display("bp hold: irdy=%0d ov=%0d", in_ready, out_valid);
        drive(1, bp[7], 0, 3'd2, 1);
        chk("bp.pop.in_ready", {95'd0, in_ready}, 96'd0);
        chk_row("bp.pop", {bp[1], bp[2], bp[3]}, 3, 2);
        $display("bp pop: irdy=%0d ov=%0d", in_ready, out_valid);
        drive(1, bp[7], 0, 3'd2, 0);
        chk("bp.row2.in_ready", {95'd0, in_ready}, 96'd1);
        chk_row("bp.row2", {bp[4], bp[5], bp[6]}, 3, 2);
        $display("bp row2: irdy=%0d ov=%0d", in_ready, out_valid);
        drive(1, bp[8], 0, 3'd2, 1);
        chk_row("bp.row2b", {bp[4], bp[5], bp[6]}, 3, 2);
        drive(1, bp[9], 1, 3'd2, 0);
        chk("bp.drained.out_valid", {95'd0, out_valid}, 96'd0);
        drive(0, 32'h0, 0, 3'd0, 0);
        chk_row("bp.row3", {bp[7], bp[8], bp[9]}, 3, 2);
        $display("bp row3: irdy=%0d ov=%0d cnt=%0d", in_ready, out_valid, out_count);

        // Reset mid-row with a held output row
        drive(1, 32'hF1F1F1F1, 0, 3'd3, 0);
        drive(1, 32'hF2F2F2F2, 0, 3'd3, 0);
        drive(0, 32'h0, 0, 3'd0, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst.in_ready", {95'd0, in_ready}, 96'd1);
        chk("arst.out_valid", {95'd0, out_valid}, 96'd0);
        chk("arst.out_data", out_data, 96'd0);
        chk("arst.out_count", {94'd0, out_count}, 96'd0);
        chk("arst.out_block_idx", {93'd0, out_block_idx}, 96'd0);
        chk("arst.err_block", {95'd0, err_block}, 96'd0);
        $display("async reset: irdy=%0d ov=%0d err=%0d", in_ready, out_valid, err_block);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 32'hD0000001, 0, 3'd6, 1);
        drive(1, 32'hD0000002, 0, 3'd6, 1);
        drive(1, 32'hD0000003, 0, 3'd6, 1);
        drive(0, 32'h0, 0, 3'd0, 1);
        chk_row("post_rst", {32'hD0000001, 32'hD0000002, 32'hD0000003}, 3, 6);
        chk("post_rst.err_block", {95'd0, err_block}, 96'd0);
        $display("post reset row: ov=%0d cnt=%0d tag=%0d", out_valid, out_count, out_block_idx);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pooling_output_packer.md
# pooling_output_packer

Serial-to-parallel packer at the back end of the pooling layer. It collects pooled results, one `DATA_WIDTH` word per cycle, and assembles them into a `PACK_SIZE`-word row for write-back to the feature-map buffer. It is the mirror of the pooling input serializer: the first word received occupies the most significant slot. Valid/ready handshakes are used on both sides, and a short row can be closed early.

## Interface
- `DATA_WIDTH`, 32: width of one pooled value.
- `PACK_SIZE`, 3: words per packed output row.
- `CNT_W`, 2: width of word counters; must satisfy 2^`CNT_W` > `PACK_SIZE`.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: `in_data` is valid this cycle.
- `in_ready` out 1: packer accepts a word this cycle.
- `in_data` in `DATA_WIDTH`: pooled value.
- `in_last` in 1: the accepted word closes the current row, even if the row is short.
- `block_idx_in` in 3: block tag of the incoming word.
- `out_valid` out 1: packed row available.
- `out_ready` in 1: consumer takes the row this cycle.
- `out_data` out `PACK_SIZE*DATA_WIDTH`: packed row. Slot k sits at bits [(`PACK_SIZE`-k)*`DATA_WIDTH`-1 : (`PACK_SIZE`-k-1)*`DATA_WIDTH`].
- `out_count` out `CNT_W`: number of valid words in `out_data`, range 1..`PACK_SIZE`.
- `out_block_idx` out 3: block tag of the row.
- `err_block` out 1: sticky flag, set when the block tag changes mid-row.

## Operation
- Input accept: a word is accepted when `in_valid && in_ready`.
- Fill register: holds slots 0..`PACK_SIZE`-1, a fill count `fcnt`, a captured tag `ftag` and a `closed` flag.
  - An accepted word goes to slot `fcnt`, then `fcnt` increments.
  - On the first word of a row (`fcnt`==0), `ftag` <= `block_idx_in`.
- Row close: the row closes when an accepted word makes `fcnt`==`PACK_SIZE`, or when `in_last` is set on the accepted word.
- Unused slots of a short row are zero in `out_data`.
- Output register: holds one row plus `out_count` and `out_block_idx`. It is free when `!out_valid || out_ready`.
- Transfer on close:
  - If the output register is free in the closing cycle, the assembled row loads directly into it at that edge. The fill register clears (`fcnt`=0, slots zeroed, `closed`=0).
  - Otherwise `closed`=1 and `in_ready`=0. The row transfers at the first edge where `out_ready` is high, and the fill register clears at the same edge.
- `in_ready` = !`closed`.
- Output handshake:
  - `out_valid` rises on a transfer.
  - It falls on `out_ready` unless a new transfer occurs at the same edge; in that case it stays high with the new row.
  - `out_data`, `out_count` and `out_block_idx` hold stable while `out_valid && !out_ready`.
- Tag check: if `fcnt`>0 and an accepted word's `block_idx_in` != `ftag`, then `err_block` <= 1. The word is still packed, and the row keeps `ftag`. `err_block` clears only on reset.
- Reset mid-row discards the partial fill and any held output row.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0, `out_data`=0, `out_count`=0, `out_block_idx`=0, `err_block`=0.
  - Internally: `fcnt`=0, `closed`=0.
- Latency: `out_valid` is high the cycle after the closing word is accepted, provided the output register is free.
- Throughput: with `out_ready` held at 1, `in_ready` stays 1. One word per cycle is sustained, giving one row per `PACK_SIZE` cycles.
- Backpressure:
  - While the output register is occupied and unconsumed, at most one further row can be closed and held.
  - `in_ready` drops in the cycle after that second close.
  - `in_ready` returns high the cycle after the edge on which `out_ready` was sampled high.
- `in_last` with `fcnt`==`PACK_SIZE`-1 is a normal full row, with `out_count`=`PACK_SIZE`.
- `in_last`/`in_data` are ignored when `in_valid`=0 or `in_ready`=0.

## Test plan
- **Full row:** `out_ready`=1; words A, B, C on consecutive cycles, tag 2.
  - Expect one cycle after C: `out_valid`=1, `out_data`={A,B,C}, `out_count`=3, `out_block_idx`=2.
- **Short row:** X, then Y with `in_last`=1.
  - Expect `out_data`={X,Y,0}, `out_count`=2. The next word starts in slot 0.
- **Backpressure:** `out_ready`=0; stream 7 words.
  - Expect row1 held stable and row2 closed.
  - `in_ready`=0 from the cycle after word 6; word 7 is not accepted.
  - Raise `out_ready` for 1 cycle: expect row2 on the output next cycle, `in_ready`=1, and word 7 accepted.
- **Streaming:** `out_ready`=1; 9 words back to back.
  - Expect 3 rows on cycles 4, 7, 10 (word 1 = cycle 1).
  - `in_ready` never low and no gaps.
- **Tag mismatch:** row words tagged 1, 1, 4.
  - Expect `err_block`=1 (sticky), `out_block_idx`=1, all 3 words packed.
- **Reset mid-row:** 2 words accepted, then `rst_n`=0 asynchronously.
  - Expect immediately: all outputs at reset values.
  - After release, a fresh 3-word row packs from slot 0 with `out_count`=3.
